// File: rtl/alu_op_sequencer_if.sv
// Request/result bundle between the decode stage and the ALU op sequencer.
//   start   : request strobe from decode
//   Signal  : R-type funct code of the request
//   ready   : sequencer idle, start will be accepted
//   select  : result-mux select (0 ALU, 1 HI, 2 LO, 3 shifter)
//   div_init/div_step/hilo_we : divider and HI/LO control
//   done    : one-cycle result-valid pulse
//   count   : divider iteration counter (debug)
//   illegal : unknown-funct trap pulse (only with ILLEGAL_TRAP_EN defined)
// Modports: master = decode side, slave = sequencer.
interface alu_op_sequencer_if;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 6;

    logic               start;
    logic [FUNCT_W-1:0] Signal;
    logic               ready;
    logic [SEL_W-1:0]   select;
    logic               div_init;
    logic               div_step;
    logic               hilo_we;
    logic               done;
    logic [CNT_W-1:0]   count;
`ifdef ILLEGAL_TRAP_EN
    logic               illegal;
`endif

`ifdef ILLEGAL_TRAP_EN
    modport master (
        output start, Signal,
        input  ready, select, div_init, div_step, hilo_we, done, count, illegal
    );
    modport slave (
        input  start, Signal,
        output ready, select, div_init, div_step, hilo_we, done, count, illegal
    );
`else
    modport master (
        output start, Signal,
        input  ready, select, div_init, div_step, hilo_we, done, count
    );
    modport slave (
        input  start, Signal,
        output ready, select, div_init, div_step, hilo_we, done, count
    );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for the ALU result path: accepts one funct code per
// request, drives the result-mux select, and sequences the iterative DIVU
// unit (init, DIV_CYCLES steps, HI/LO write-back).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : alu_op_sequencer_if.slave (start/Signal in; ready, select,
//           div_init, div_step, hilo_we, done, count out)
// Optional: define ILLEGAL_TRAP_EN to add bus.illegal and trap unknown funct
// codes; otherwise unknown codes are treated as SRL.
module alu_op_sequencer #(
    parameter int unsigned DIV_CYCLES = 32   // legal range 1..63
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus
);
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 6;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'b000010;
    localparam logic [FUNCT_W-1:0] FN_DIVU = 6'b011011;
    localparam logic [FUNCT_W-1:0] FN_MFHI = 6'b010000;
    localparam logic [FUNCT_W-1:0] FN_MFLO = 6'b010010;

    localparam logic [SEL_W-1:0] SEL_ALU = 2'd0;
    localparam logic [SEL_W-1:0] SEL_HI  = 2'd1;
    localparam logic [SEL_W-1:0] SEL_LO  = 2'd2;
    localparam logic [SEL_W-1:0] SEL_SHF = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        DIV_INIT = 3'd2,
        DIV_RUN  = 3'd3,
        DIV_WB   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [FUNCT_W-1:0] op_q, op_d;
    logic [SEL_W-1:0]   select_q, select_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               div_init_q, div_init_d;
    logic               div_step_q, div_step_d;
    logic               hilo_we_q, hilo_we_d;
    logic               done_q, done_d;
`ifdef ILLEGAL_TRAP_EN
    logic               illegal_q, illegal_d;
`endif

    logic [SEL_W-1:0]   dec_sel;
    logic               dec_div;
`ifdef ILLEGAL_TRAP_EN
    logic               dec_known;
`endif

    // Funct decode of the incoming request; unknown codes fall to the shifter
    // select unless the trap is built in.
    always_comb begin
        dec_sel   = SEL_SHF;
        dec_div   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        dec_known = 1'b1;
`endif
        case (bus.Signal)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: dec_sel = SEL_ALU;
            FN_SRL:  dec_sel = SEL_SHF;
            FN_MFHI: dec_sel = SEL_HI;
            FN_MFLO: dec_sel = SEL_LO;
            FN_DIVU: dec_div = 1'b1;
            default: begin
`ifdef ILLEGAL_TRAP_EN
                dec_known = 1'b0;
`endif
            end
        endcase
    end

    // Next-state and registered-output logic. Pulse outputs are decoded from
    // the state being entered so they line up with that state's cycle.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        select_d   = select_q;
        count_d    = count_q;
        div_init_d = 1'b0;
        div_step_d = 1'b0;
        hilo_we_d  = 1'b0;
        done_d     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d = bus.Signal;
                    if (dec_div) begin
                        // DIVU leaves select untouched
                        state_d    = DIV_INIT;
                        count_d    = '0;
                        div_init_d = 1'b1;
                    end else begin
                        state_d = EXEC;
`ifdef ILLEGAL_TRAP_EN
                        if (dec_known) begin
                            select_d = dec_sel;
                            done_d   = 1'b1;
                        end else begin
                            illegal_d = 1'b1;
                        end
`else
                        select_d = dec_sel;
                        done_d   = 1'b1;
`endif
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
            end
            DIV_INIT: begin
                state_d    = DIV_RUN;
                div_step_d = 1'b1;
            end
            DIV_RUN: begin
                if (count_q == LAST_CNT) begin
                    // Write-back only for a genuine DIVU; a corrupted op aborts
                    if (op_q == FN_DIVU) begin
                        state_d   = DIV_WB;
                        hilo_we_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d    = count_q + CNT_W'(1);
                    div_step_d = 1'b1;
                end
            end
            DIV_WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            select_q   <= SEL_ALU;
            count_q    <= '0;
            div_init_q <= 1'b0;
            div_step_q <= 1'b0;
            hilo_we_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            select_q   <= select_d;
            count_q    <= count_d;
            div_init_q <= div_init_d;
            div_step_q <= div_step_d;
            hilo_we_q  <= hilo_we_d;
            done_q     <= done_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.select   = select_q;
    assign bus.count    = count_q;
    assign bus.div_init = div_init_q;
    assign bus.div_step = div_step_q;
    assign bus.hilo_we  = hilo_we_q;
    assign bus.done     = done_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal  = illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: reset values, a table of single-cycle
// ops, back-to-back mux codes, a full DIVU with a held busy request, and a
// reset that aborts a divide in progress.
module tb_alu_op_sequencer;
    localparam int unsigned DC = 32;

    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_BAD  = 6'b111111;

    typedef struct {
        logic [5:0] funct;
        logic [1:0] exp_sel;
        logic       exp_done;
        logic       exp_ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_op_sequencer_if bus();

    alu_op_sequencer #(.DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {ready, div_init, div_step, hilo_we, done, select[1:0], count[5:0]}
    function automatic logic [12:0] obs();
        return {bus.ready, bus.div_init, bus.div_step, bus.hilo_we, bus.done,
                bus.select, bus.count};
    endfunction

    function automatic logic [12:0] pack(input logic rdy, input logic ini, input logic stp,
                                         input logic we, input logic dn,
                                         input logic [1:0] sel, input logic [5:0] cnt);
        return {rdy, ini, stp, we, dn, sel, cnt};
    endfunction

    vec_t vecs[10];
    logic [5:0] mux_ops[3];
    logic [1:0] mux_sel[3];

    initial begin
        vecs[0] = '{FN_ADD,  2'd0, 1'b1, 1'b0};
        vecs[1] = '{FN_SRL,  2'd3, 1'b1, 1'b0};
        vecs[2] = '{FN_AND,  2'd0, 1'b1, 1'b0};
        vecs[3] = '{FN_MFHI, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{FN_OR,   2'd0, 1'b1, 1'b0};
        vecs[5] = '{FN_MFLO, 2'd2, 1'b1, 1'b0};
        vecs[6] = '{FN_SUB,  2'd0, 1'b1, 1'b0};
        vecs[7] = '{FN_SLT,  2'd0, 1'b1, 1'b0};
        vecs[8] = '{FN_MFLO, 2'd2, 1'b1, 1'b0};
`ifdef ILLEGAL_TRAP_EN
        vecs[9] = '{FN_BAD,  2'd2, 1'b0, 1'b1};
`else
        vecs[9] = '{FN_BAD,  2'd3, 1'b1, 1'b0};
`endif
        mux_ops[0] = FN_MFHI; mux_sel[0] = 2'd1;
        mux_ops[1] = FN_MFLO; mux_sel[1] = 2'd2;
        mux_ops[2] = FN_SRL;  mux_sel[2] = 2'd3;

        // Reset state
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        #12;
        check("reset_state", 32'(obs()), 32'(pack(1, 0, 0, 0, 0, 2'd0, 6'd0)));
`ifdef ILLEGAL_TRAP_EN
        check("reset_illegal", 32'(bus.illegal), 32'd0);
`endif
        reset = 1'b1;
        tick();

        // Table of single-cycle ops, each issued alone
        for (int i = 0; i < 10; i++) begin
            bus.start  = 1'b1;
            bus.Signal = vecs[i].funct;
            tick();
            bus.start = 1'b0;
            check($sformatf("vec%0d_exec", i), 32'(obs()),
                  32'(pack(0, 0, 0, 0, vecs[i].exp_done, vecs[i].exp_sel, 6'd0)));
`ifdef ILLEGAL_TRAP_EN
            check($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 32'(vecs[i].exp_ill));
`endif
            tick();
            check($sformatf("vec%0d_idle", i), 32'(obs()),
                  32'(pack(1, 0, 0, 0, 0, vecs[i].exp_sel, 6'd0)));
        end

        // MFHI, MFLO, SRL at the maximum issue rate with start held
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.Signal = mux_ops[i];
            tick();
            check($sformatf("mux%0d_exec", i), 32'(obs()),
                  32'(pack(0, 0, 0, 0, 1, mux_sel[i], 6'd0)));
            tick();
            check($sformatf("mux%0d_gap", i), 32'(obs()),
                  32'(pack(1, 0, 0, 0, 0, mux_sel[i], 6'd0)));
            if (i == 2) bus.start = 1'b0;
        end

        // DIVU at edge 0, then OR held high through the busy span
        bus.start  = 1'b1;
        bus.Signal = FN_DIVU;
        tick();
        bus.Signal = FN_OR;
        for (int c = 1; c <= 36; c++) begin
            logic [5:0] ecnt;
            logic [1:0] esel;
            ecnt = (c <= 1) ? 6'd0 : (c <= 33) ? 6'(c - 2) : 6'(DC - 1);
            esel = (c == 36) ? 2'd0 : 2'd3;
            check($sformatf("div_cycle%0d", c), 32'(obs()),
                  32'(pack(c == 35, c == 1, (c >= 2) && (c <= 33), c == 34,
                           (c == 34) || (c == 36), esel, ecnt)));
            if (c < 36) tick();
        end
        bus.start = 1'b0;
        tick();
        check("div_after_or", 32'(obs()), 32'(pack(1, 0, 0, 0, 0, 2'd0, 6'(DC - 1))));

        // Reset during DIV_RUN cycle 5 aborts the divide
        bus.start  = 1'b1;
        bus.Signal = FN_MFLO;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start  = 1'b1;
        bus.Signal = FN_DIVU;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("abort_pre", 32'(obs()), 32'(pack(0, 0, 1, 0, 0, 2'd2, 6'd4)));
        #2;
        reset = 1'b0;
        #1;
        check("abort_reset", 32'(obs()), 32'(pack(1, 0, 0, 0, 0, 2'd0, 6'd0)));
        @(negedge clk);
        reset = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (bus.hilo_we || bus.done || !bus.ready) pulses++;
            end
            check("abort_no_wb", 32'(pulses), 32'd0);
        end
        check("abort_final", 32'(obs()), 32'(pack(1, 0, 0, 0, 0, 2'd0, 6'd0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
